// File: rtl/softmax_result_tx.sv
// softmax_result_tx: snapshots a classifier result and streams it as a framed
// word sequence (header, max, scores) over valid/ready. Option: SOFTMAX_TX_CHECKSUM_EN.
module softmax_result_tx #(
    parameter int DATAWIDTH   = 32,
    parameter int NUM_CLASSES = 10,
    parameter int INDEXWIDTH  = 4
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             start,
    input  logic [NUM_CLASSES*DATAWIDTH-1:0] scores_in,
    input  logic [DATAWIDTH-1:0]             max_in,
    input  logic [INDEXWIDTH-1:0]            index_in,
    output logic                             busy,
    output logic [DATAWIDTH-1:0]             tx_data,
    output logic                             tx_valid,
    input  logic                             tx_ready,
    output logic                             tx_last,
    output logic                             done
);

    localparam int CW = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NUM_CLASSES - 1);

`ifdef SOFTMAX_TX_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_MAX, S_SCORE, S_CHK, S_FIN
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_MAX, S_SCORE, S_FIN
    } state_t;
`endif

    state_t                r_state;
    state_t                w_next;
    logic [DATAWIDTH-1:0]  r_scores [NUM_CLASSES];
    logic [DATAWIDTH-1:0]  r_max;
    logic [INDEXWIDTH-1:0] r_index;
    logic                  r_invalid;
    logic [CW-1:0]         r_cnt;
    logic [DATAWIDTH-1:0]  w_hdr;
    logic                  w_cap;

    // A start is only honoured while idle; otherwise the snapshot is kept.
    assign w_cap = (r_state == S_IDLE) && start;

    // Header word assembled from the captured index and invalid flag.
    always_comb begin
        w_hdr = '0;
        w_hdr[DATAWIDTH-1 -: 8]  = 8'hA5;
        w_hdr[DATAWIDTH-9 -: 8]  = 8'(NUM_CLASSES);
        w_hdr[DATAWIDTH-17]      = r_invalid;
        w_hdr[INDEXWIDTH-1:0]    = r_index;
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Snapshot capture on an accepted start.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_CLASSES; k++) r_scores[k] <= '0;
            r_max     <= '0;
            r_index   <= '0;
            r_invalid <= 1'b0;
        end else if (w_cap) begin
            for (int k = 0; k < NUM_CLASSES; k++)
                r_scores[k] <= scores_in[k*DATAWIDTH +: DATAWIDTH];
            r_max     <= max_in;
            r_index   <= index_in;
            r_invalid <= (32'(index_in) >= 32'(NUM_CLASSES));
        end
    end

    // Class counter: cleared entering SCORE, steps per accepted score beat.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (r_state == S_MAX && tx_ready) begin
            r_cnt <= '0;
        end else if (r_state == S_SCORE && tx_ready && r_cnt != LAST_CNT) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

`ifdef SOFTMAX_TX_CHECKSUM_EN
    logic [DATAWIDTH-1:0] r_chk;

    // Running XOR of every accepted frame word; cleared on capture.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                      r_chk <= '0;
        else if (w_cap)                 r_chk <= '0;
        else if (tx_valid && tx_ready)  r_chk <= r_chk ^ tx_data;
    end
`endif

    // Next state and outputs; valid is a pure function of state.
    always_comb begin
        w_next   = r_state;
        busy     = 1'b0;
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        tx_data  = '0;
        done     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_HDR;
            end
            S_HDR: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_data  = w_hdr;
                if (tx_ready) w_next = S_MAX;
            end
            S_MAX: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_data  = r_max;
                if (tx_ready) w_next = S_SCORE;
            end
            S_SCORE: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_data  = r_scores[r_cnt];
`ifdef SOFTMAX_TX_CHECKSUM_EN
                if (tx_ready && r_cnt == LAST_CNT) w_next = S_CHK;
`else
                tx_last  = (r_cnt == LAST_CNT);
                if (tx_ready && r_cnt == LAST_CNT) w_next = S_FIN;
`endif
            end
`ifdef SOFTMAX_TX_CHECKSUM_EN
            S_CHK: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_last  = 1'b1;
                tx_data  = r_chk;
                if (tx_ready) w_next = S_FIN;
            end
`endif
            S_FIN: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_softmax_result_tx.sv
// tb_softmax_result_tx: directed frames with hand-computed words, stalls,
// ignored starts, invalid index and mid-frame reset.
module tb_softmax_result_tx;

    localparam int DW = 32;
    localparam int NC = 10;
    localparam int IW = 4;
`ifdef SOFTMAX_TX_CHECKSUM_EN
    localparam int NB = NC + 3;
`else
    localparam int NB = NC + 2;
`endif

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [NC*DW-1:0] scores_in = '0;
    logic [DW-1:0]    max_in = '0;
    logic [IW-1:0]    index_in = '0;
    logic             busy;
    logic [DW-1:0]    tx_data;
    logic             tx_valid;
    logic             tx_ready = 1'b0;
    logic             tx_last;
    logic             done;

    int total = 0;
    int bad   = 0;

    softmax_result_tx #(.DATAWIDTH(DW), .NUM_CLASSES(NC), .INDEXWIDTH(IW)) dut (
        .clock(clock), .reset(reset), .start(start),
        .scores_in(scores_in), .max_in(max_in), .index_in(index_in),
        .busy(busy), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_last(tx_last), .done(done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_inputs(input logic [IW-1:0] idx, input logic [31:0] mx,
                              input logic [31:0] base, input logic [31:0] step);
        index_in = idx;
        max_in   = mx;
        for (int k = 0; k < NC; k++)
            scores_in[k*DW +: DW] = base + step * k;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_valid", tx_valid, 1);
    endtask

    // mode 0: ready always high; mode 1: ready pattern 1,0,0,1
    task automatic recv_frame(input int mode, input logic [31:0] hdr,
                              input logic [31:0] mx, input logic [31:0] base,
                              input bit perturb);
        logic [31:0] exp [NB];
        logic [31:0] held;
        logic [31:0] x;
        bit stalled;
        bit rdy;
        int beats;
        int cyc;
        exp[0] = hdr;
        exp[1] = mx;
        for (int k = 0; k < NC; k++) exp[2+k] = base + 32'h100 * k;
`ifdef SOFTMAX_TX_CHECKSUM_EN
        x = '0;
        for (int k = 0; k < NB - 1; k++) x = x ^ exp[k];
        exp[NB-1] = x;
`endif
        held = '0;
        stalled = 0;
        beats = 0;
        cyc = 0;
        while (beats < NB && cyc < 200) begin
            rdy = (mode == 0) || (cyc % 4 == 0) || (cyc % 4 == 3);
            tx_ready = rdy;
            if (perturb && cyc == 3) begin
                start = 1'b1;
                set_inputs(4'd7, 32'h1234_5678, 32'hDEAD_0000, 32'h1);
            end else begin
                start = 1'b0;
            end
            if (tx_valid !== 1'b1) begin
                chk("valid_midframe", tx_valid, 1);
                break;
            end
            if (stalled) chk("stall_hold", tx_data, held);
            if (rdy) begin
                chk("beat_data", tx_data, exp[beats]);
                chk("beat_last", tx_last, (beats == NB - 1) ? 1 : 0);
                beats++;
                stalled = 0;
            end else begin
                stalled = 1;
                held = tx_data;
            end
            tick();
            cyc++;
        end
        start = 1'b0;
        tx_ready = 1'b0;
        chk("beat_count", beats, NB);
        chk("fin_done", done, 1);
        chk("fin_busy", busy, 0);
        chk("fin_valid", tx_valid, 0);
        tick();
        chk("done_pulse", done, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("no_extra_frame", tx_valid, 0);
        end
    endtask

    initial begin
        #2;
        chk("rst_valid", tx_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_last", tx_last, 0);
        chk("rst_data", tx_data, 0);
        tick();
        reset = 1'b0;
        tick();

        // basic frame, ready held high
        set_inputs(4'd3, 32'h3F00_0000, 32'h0, 32'h100);
        do_start();
        recv_frame(0, 32'hA50A_0003, 32'h3F00_0000, 32'h0, 0);

        // same frame under back-pressure
        do_start();
        recv_frame(1, 32'hA50A_0003, 32'h3F00_0000, 32'h0, 0);

        // second start mid-frame with new inputs is ignored
        set_inputs(4'd3, 32'h3F00_0000, 32'h0, 32'h100);
        do_start();
        recv_frame(0, 32'hA50A_0003, 32'h3F00_0000, 32'h0, 1);

        // out-of-range index sets invalid flag
        set_inputs(4'd12, 32'h3E80_0000, 32'h0, 32'h100);
        do_start();
        recv_frame(1, 32'hA50A_800C, 32'h3E80_0000, 32'h0, 0);

        // reset while score beat 5 is stalled
        set_inputs(4'd5, 32'h3F00_0000, 32'h0, 32'h100);
        do_start();
        tx_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        tx_ready = 1'b0;
        chk("pre_rst_data", tx_data, 32'h400);
        tick();
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_valid", tx_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        tick();
        chk("rsthold_done", done, 0);
        reset = 1'b0;
        tick();
        chk("postrst_valid", tx_valid, 0);
        set_inputs(4'd9, 32'h3F40_0000, 32'h0, 32'h100);
        do_start();
        recv_frame(0, 32'hA50A_0009, 32'h3F40_0000, 32'h0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
